dcache_refill_engine: RTL and testbench

Responder side of the dCache miss-repair handshake. It watches the controller's read_repair_request and missed_addr, fetches the missing 1024-bit block from backing memory as 32 word-sized beats, and writes the assembled block into the cache with a full-mask write. It then pulses repair_resolved. It sits between dCacheController (via the arbiter-side signals) and the memory port.

---
 rtl/dcache_refill_engine_if.sv | 55 +++++
 rtl/dcache_refill_engine.sv | 156 +++++++++++++++
 tb/tb_dcache_refill_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_refill_engine_if.sv
// Bundle of the controller-side repair handshake, cache block write port and memory read port
// as seen by dcache_refill_engine.
interface dcache_refill_engine_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BLOCK_W = 1024,
  parameter int unsigned MEM_W   = 32
);
  logic                   read_repair_request;
  logic [ADDR_W-1:0]      missed_addr;
  logic                   waddr_valid;
  logic [ADDR_W-1:0]      waddr;
  logic [BLOCK_W-1:0]     wdata;
  logic [BLOCK_W/8-1:0]   wmask;
  logic                   repair_resolved;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic                   mem_rsp_valid;
  logic [MEM_W-1:0]       mem_rsp_data;
  logic                   busy;

  // Refill engine side.
  modport master (
    input  read_repair_request,
    input  missed_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    output waddr_valid,
    output waddr,
    output wdata,
    output wmask,
    output repair_resolved,
    output mem_req_valid,
    output mem_req_addr,
    output busy
  );

  // Controller / memory side.
  modport slave (
    output read_repair_request,
    output missed_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    input  waddr_valid,
    input  waddr,
    input  wdata,
    input  wmask,
    input  repair_resolved,
    input  mem_req_valid,
    input  mem_req_addr,
    input  busy
  );
endinterface

// File: rtl/dcache_refill_engine.sv
// dCache miss-repair responder: fetches a missing block as word beats from memory, writes it
// back to the cache with a full mask and pulses repair_resolved.
module dcache_refill_engine #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BLOCK_W         = 1024,
  parameter int unsigned MEM_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                    clk,
  input logic                    rst,
  dcache_refill_engine_if.master bus
);

  localparam int unsigned BEATS      = BLOCK_W / MEM_W;
  localparam int unsigned CNT_W      = $clog2(BEATS + 1);
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BLK_OFF_W  = $clog2(BLOCK_W / 8);
  localparam int unsigned BEAT_OFF_W = $clog2(MEM_W / 8);
  localparam int unsigned MASK_W     = BLOCK_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWrite,
    StResolve,
    StDrain
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]   buf_q, buf_d;
  logic [MASK_W-1:0]    wmask_q, wmask_d;
  logic [CNT_W-1:0]     req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]     rsp_cnt_q, rsp_cnt_d;
  logic [OUT_W-1:0]     outst_q, outst_d;

  logic capture;
  logic req_valid;
  logic req_fire;
  logic rsp_fire;
  logic last_rsp;
  logic waddr_valid;
  logic resolved;

  assign capture  = (state_q == StIdle) && bus.read_repair_request;
  assign req_fire = req_valid && bus.mem_req_ready;
  // Responses are only meaningful while fetching and something is actually in flight.
  assign rsp_fire = (state_q == StFetch) && bus.mem_rsp_valid && (outst_q != '0) &&
                    (rsp_cnt_q < CNT_W'(BEATS));
  assign last_rsp = rsp_fire && (rsp_cnt_q == CNT_W'(BEATS - 1));

  // FSM next state and decoded outputs.
  always_comb begin
    state_d     = state_q;
    req_valid   = 1'b0;
    waddr_valid = 1'b0;
    resolved    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.read_repair_request) state_d = StFetch;
      end
      StFetch: begin
        req_valid = (req_cnt_q < CNT_W'(BEATS)) && (outst_q < OUT_W'(MAX_OUTSTANDING));
        if (last_rsp) state_d = StWrite;
      end
      StWrite: begin
        waddr_valid = 1'b1;
        state_d     = StResolve;
      end
      StResolve: begin
        resolved = 1'b1;
        state_d  = StDrain;
      end
      StDrain: begin
        // Hold off until the level request drops so it cannot re-trigger a refill.
        if (!bus.read_repair_request) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture, beat counters, in-flight tracking and block assembly.
  always_comb begin
    base_d    = base_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    wmask_d   = wmask_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    outst_d   = outst_q;
    if (capture) begin
      base_d    = {bus.missed_addr[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
      addr_d    = bus.missed_addr;
      buf_d     = '0;
      wmask_d   = '0;
      req_cnt_d = '0;
      rsp_cnt_d = '0;
      outst_d   = '0;
    end else begin
      if (req_fire) req_cnt_d = req_cnt_q + CNT_W'(1);
      if (rsp_fire) begin
        rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (rsp_cnt_q == CNT_W'(b)) buf_d[b*MEM_W +: MEM_W] = bus.mem_rsp_data;
        end
      end
      unique case ({req_fire, rsp_fire})
        2'b10:   outst_d = outst_q + OUT_W'(1);
        2'b01:   outst_d = outst_q - OUT_W'(1);
        default: outst_d = outst_q;
      endcase
      if (last_rsp) wmask_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      addr_q    <= '0;
      buf_q     <= '0;
      wmask_q   <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      outst_q   <= '0;
    end else begin
      base_q    <= base_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      wmask_q   <= wmask_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      outst_q   <= outst_d;
    end
  end

  assign bus.waddr_valid     = waddr_valid;
  assign bus.repair_resolved = resolved;
  assign bus.busy            = (state_q != StIdle);
  assign bus.mem_req_valid   = req_valid;
  assign bus.mem_req_addr    = (state_q == StFetch) ?
                               base_q + (ADDR_W'(req_cnt_q) << BEAT_OFF_W) : '0;
  // Write port reflects the buffer and captured address; they hold through RESOLVE.
  assign bus.waddr           = addr_q;
  assign bus.wdata           = buf_q;
  assign bus.wmask           = wmask_q;

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Directed bench for dcache_refill_engine with an in-order, fixed-latency memory model.
module tb_dcache_refill_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_refill_engine_if #(.ADDR_W(32), .BLOCK_W(1024), .MEM_W(32)) bus ();

  dcache_refill_engine #(
    .ADDR_W(32), .BLOCK_W(1024), .MEM_W(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int          mem_lat = 1;
  logic [3:0]  rdy_pat = 4'hF;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc[$];
  int          rsp_seen, inflight, max_inflight, acc_at_first_rsp, stall_bad;
  int          wr_cnt, res_cnt, wr_cyc, res_cyc, start_cyc;
  logic [31:0] wr_addr;
  logic [1023:0] wr_data;
  logic [127:0]  wr_mask;
  logic          prev_stall;
  logic [31:0]   prev_addr;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    q_addr.delete();
    q_due.delete();
    acc.delete();
    rsp_seen = 0; inflight = 0; max_inflight = 0; acc_at_first_rsp = 0; stall_bad = 0;
    wr_cnt = 0; res_cnt = 0; wr_cyc = 0; res_cyc = 0;
    wr_addr = '0; wr_data = '0; wr_mask = '0;
    prev_stall = 1'b0; prev_addr = '0;
  endtask

  // One clock: observe at the falling edge, then drive memory-side inputs for the next edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (bus.waddr_valid) begin
      wr_cnt++; wr_cyc = cyc; wr_addr = bus.waddr; wr_data = bus.wdata; wr_mask = bus.wmask;
    end
    if (bus.repair_resolved) begin
      res_cnt++; res_cyc = cyc;
    end
    if (prev_stall && (!bus.mem_req_valid || bus.mem_req_addr !== prev_addr)) stall_bad++;
    bus.mem_req_ready = rdy_pat[cyc[1:0]];
    prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
    prev_addr  = bus.mem_req_addr;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      acc.push_back(bus.mem_req_addr);
      q_addr.push_back(bus.mem_req_addr);
      q_due.push_back(cyc + mem_lat);
      inflight++;
    end
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      if (rsp_seen == 0) acc_at_first_rsp = acc.size();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = q_addr.pop_front();
      void'(q_due.pop_front());
      inflight--;
      rsp_seen++;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
    end
    if (inflight > max_inflight) max_inflight = inflight;
  endtask

  task automatic refill(input string tag, input logic [31:0] addr, input int lat,
                        input logic [3:0] pat, input int hold);
    logic [31:0]   base;
    logic [1023:0] exp;
    int n, bad;
    clear_stats();
    mem_lat = lat;
    rdy_pat = pat;
    base = {addr[31:7], 7'b0};
    for (int i = 0; i < 32; i++) exp[i*32 +: 32] = base + 32'(i * 4);
    bus.read_repair_request = 1'b1;
    bus.missed_addr         = addr;
    start_cyc = cyc;
    cycle();
    bus.missed_addr = ~addr;  // must be ignored after capture
    n = 0;
    while (res_cnt == 0 && n < 2000) begin
      cycle();
      n++;
    end
    check({tag, "/done"}, 1024'(res_cnt != 0), 1024'(1));
    check({tag, "/wr_cnt"}, 1024'(wr_cnt), 1024'(1));
    check({tag, "/waddr"}, 1024'(wr_addr), 1024'(addr));
    check({tag, "/wdata"}, wr_data, exp);
    check({tag, "/wmask"}, 1024'(wr_mask), 1024'({128{1'b1}}));
    check({tag, "/resolve_next"}, 1024'(res_cyc), 1024'(wr_cyc + 1));
    check({tag, "/n_req"}, 1024'(acc.size()), 1024'(32));
    bad = 0;
    for (int i = 0; i < acc.size() && i < 32; i++) if (acc[i] !== base + 32'(i * 4)) bad++;
    check({tag, "/req_addrs"}, 1024'(bad), 1024'(0));
    check({tag, "/stall_stable"}, 1024'(stall_bad), 1024'(0));
    check({tag, "/max_inflight_le4"}, 1024'(max_inflight <= 4), 1024'(1));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      cycle();
      if (!bus.busy || bus.mem_req_valid) bad++;
    end
    if (hold > 0) check({tag, "/drain_held"}, 1024'(bad), 1024'(0));
    bus.read_repair_request = 1'b0;
    cycle();
    if (hold == 0) begin
      check({tag, "/drain_busy"}, 1024'(bus.busy), 1024'(1));
      cycle();
    end
    check({tag, "/idle"}, 1024'(bus.busy), 1024'(0));
  endtask

  initial begin
    int n;
    bus.read_repair_request = 1'b0;
    bus.missed_addr         = '0;
    bus.mem_req_ready       = 1'b0;
    bus.mem_rsp_valid       = 1'b0;
    bus.mem_rsp_data        = '0;
    clear_stats();
    #1;
    check("por/busy", 1024'(bus.busy), 1024'(0));
    check("por/strobes", 1024'({bus.waddr_valid, bus.repair_resolved, bus.mem_req_valid}),
          1024'(0));
    check("por/waddr_addr", 1024'({bus.waddr, bus.mem_req_addr}), 1024'(0));
    check("por/wdata", bus.wdata, 1024'(0));
    check("por/wmask", 1024'(bus.wmask), 1024'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic refill, ready always high, 1-cycle memory.
    refill("basic", 32'hAABB_CCDD, 1, 4'hF, 0);
    check("basic/latency_le35", 1024'((wr_cyc - start_cyc) <= 35), 1024'(1));

    // Slow memory: the outstanding window must fill to exactly 4 and stall.
    refill("outst", 32'h0000_1044, 10, 4'hF, 0);
    check("outst/acc_before_rsp", 1024'(acc_at_first_rsp), 1024'(4));
    check("outst/max_inflight", 1024'(max_inflight), 1024'(4));

    // Backpressure: ready follows 1,0,0,1 repeating.
    refill("bp", 32'h1234_5678, 1, 4'b1001, 0);

    // Request held for 5 cycles after the resolved pulse.
    refill("hold", 32'h8000_00F0, 2, 4'hF, 5);

    // Spurious response while idle, then a normal refill.
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    check("spur/idle", 1024'(bus.busy), 1024'(0));
    refill("spur", 32'hCAFE_0104, 1, 4'hF, 0);

    // Reset after 10 beats of a fetch, then restart with the request still high.
    clear_stats();
    mem_lat = 1;
    rdy_pat = 4'hF;
    bus.read_repair_request = 1'b1;
    bus.missed_addr         = 32'h5555_AAAA;
    n = 0;
    while (rsp_seen < 10 && n < 200) begin
      cycle();
      n++;
    end
    check("rst/reached_10", 1024'(rsp_seen >= 10), 1024'(1));
    #2 rst = 1'b0;
    #1;
    check("rst/busy", 1024'(bus.busy), 1024'(0));
    check("rst/strobes", 1024'({bus.waddr_valid, bus.repair_resolved, bus.mem_req_valid}),
          1024'(0));
    check("rst/waddr_addr", 1024'({bus.waddr, bus.mem_req_addr}), 1024'(0));
    check("rst/wdata", bus.wdata, 1024'(0));
    check("rst/wmask", 1024'(bus.wmask), 1024'(0));
    q_addr.delete();
    q_due.delete();
    inflight = 0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    cycle();
    rst = 1'b1;
    check("rst/no_write", 1024'({wr_cnt, res_cnt}), 1024'(0));
    refill("restart", 32'h5555_AAAA, 1, 4'hF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
